mul_pipe_unit: RTL and testbench

- Parametrised, fully pipelined RV32M/RV64M multiplier. Successor to the fixed 33x33, 3-register, clock-enable multiplier wrapper.
- Adds valid/ready handshake, per-op signedness (MUL/MULH/MULHSU/MULHU), configurable width and depth, and a pass-through tag for writeback routing.
- Sits in the execute stage beside the ALU and feeds the writeback arbiter.

---
 rtl/mul_pipe_unit.sv | 142 ++++++++++++++
 tb/tb_mul_pipe_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_pipe_unit.sv
// mul_pipe_unit: fully pipelined RV32M/RV64M multiplier with valid/ready
// handshake, per-op signedness, configurable depth and a pass-through tag.
// Optional feature: define MUL_PIPE_KILL_EN to add a 'kill' flush input.
module mul_pipe_unit #(
    parameter int XLEN   = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic              CLK_0,
    input  logic              RST_0,
`ifdef MUL_PIPE_KILL_EN
    input  logic              kill,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int PW = 2 * XLEN;

    logic              adv;
    logic              accept;
    logic              flush;
    logic [STAGES:1]   vld;
    logic [1:0]        op_q  [1:STAGES];
    logic [TAG_W-1:0]  tag_q [1:STAGES];
    logic [PW-1:0]     prod_last;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

`ifdef MUL_PIPE_KILL_EN
    assign flush = kill;
`else
    assign flush = 1'b0;
`endif

    // rs1 is signed for everything except MULHU
    function automatic logic [XLEN:0] ext_a(input logic [1:0] op, input logic [XLEN-1:0] v);
        return {(op != 2'b11) & v[XLEN-1], v};
    endfunction

    // rs2 is signed only for MUL and MULH
    function automatic logic [XLEN:0] ext_b(input logic [1:0] op, input logic [XLEN-1:0] v);
        return {!op[1] & v[XLEN-1], v};
    endfunction

    // The top two bits of the (XLEN+1)x(XLEN+1) signed product are never
    // selected, so the multiply is done modulo 2^(2*XLEN) on sign-extended
    // operands; the low 2*XLEN bits are identical to the full product.
    function automatic logic [PW-1:0] mul_ext(input logic [XLEN:0] a, input logic [XLEN:0] b);
        logic [PW-1:0] aw;
        logic [PW-1:0] bw;
        aw = {{(XLEN - 1){a[XLEN]}}, a};
        bw = {{(XLEN - 1){b[XLEN]}}, b};
        return aw * bw;
    endfunction

    // Valid chain: cleared by reset or kill, otherwise shifts on advance
    always_ff @(posedge CLK_0) begin
        if (RST_0 || flush) begin
            vld <= '0;
        end else if (adv) begin
            vld[1] <= accept;
            for (int unsigned i = 2; i <= STAGES; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // Op and tag travel alongside the data, frozen when the pipe stalls
    always_ff @(posedge CLK_0) begin
        if (RST_0) begin
            for (int unsigned i = 1; i <= STAGES; i++) begin
                op_q[i]  <= '0;
                tag_q[i] <= '0;
            end
        end else if (adv) begin
            op_q[1]  <= in_op;
            tag_q[1] <= in_tag;
            for (int unsigned i = 2; i <= STAGES; i++) begin
                op_q[i]  <= op_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    if (STAGES < 1 || STAGES > 6) begin : g_bad_stages
        $error("mul_pipe_unit: STAGES must be in 1..6");
        assign prod_last = '0;
    end else if (STAGES == 1) begin : g_single
        logic [PW-1:0] prod_q;

        // Single stage: product registered directly from the inputs
        always_ff @(posedge CLK_0) begin
            if (RST_0) begin
                prod_q <= '0;
            end else if (adv) begin
                prod_q <= mul_ext(ext_a(in_op, in_a), ext_b(in_op, in_b));
            end
        end

        assign prod_last = prod_q;
    end else begin : g_multi
        logic [XLEN:0] a_q;
        logic [XLEN:0] b_q;
        logic [PW-1:0] prod_q [2:STAGES];

        // Operands registered in stage 1, multiply into stage 2, rest is retiming
        always_ff @(posedge CLK_0) begin
            if (RST_0) begin
                a_q <= '0;
                b_q <= '0;
                for (int unsigned i = 2; i <= STAGES; i++) begin
                    prod_q[i] <= '0;
                end
            end else if (adv) begin
                a_q       <= ext_a(in_op, in_a);
                b_q       <= ext_b(in_op, in_b);
                prod_q[2] <= mul_ext(a_q, b_q);
                for (int unsigned i = 3; i <= STAGES; i++) begin
                    prod_q[i] <= prod_q[i-1];
                end
            end
        end

        assign prod_last = prod_q[STAGES];
    end

    assign out_valid  = vld[STAGES];
    assign out_tag    = tag_q[STAGES];
    assign out_result = (op_q[STAGES] == 2'b00) ? prod_last[XLEN-1:0] : prod_last[PW-1:XLEN];

endmodule

// File: tb/tb_mul_pipe_unit.sv
// tb_mul_pipe_unit: directed self-checking bench for mul_pipe_unit (XLEN=32).
// With MUL_PIPE_KILL_EN defined the DUT is built with STAGES=4 and the
// kill flush is exercised as well.
module tb_mul_pipe_unit;

`ifdef MUL_PIPE_KILL_EN
    localparam int STG = 4;
`else
    localparam int STG = 3;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
`ifdef MUL_PIPE_KILL_EN
    logic        kill;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0]  vec_op  [16];
    logic [31:0] vec_a   [16];
    logic [31:0] vec_b   [16];
    logic [4:0]  vec_tag [16];
    logic [31:0] vec_exp [16];

    mul_pipe_unit #(
        .XLEN   (32),
        .STAGES (STG),
        .TAG_W  (5)
    ) dut (
        .CLK_0      (clk),
        .RST_0      (rst),
`ifdef MUL_PIPE_KILL_EN
        .kill       (kill),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tg, input logic [31:0] exp);
        vec_op[i]  = op;
        vec_a[i]   = a;
        vec_b[i]   = b;
        vec_tag[i] = tg;
        vec_exp[i] = exp;
    endtask

    // Issue one op with out_ready high and confirm it appears exactly STG cycles later
    task automatic issue_timed(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] tg, input logic [31:0] exp);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tg;
        #1;
        check("timed_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        for (int i = 1; i < STG; i++) begin
            check("timed_early_valid", out_valid, 0);
            step();
        end
        check("timed_valid", out_valid, 1);
        check("timed_result", out_result, exp);
        check("timed_tag", out_tag, tg);
        step();
    endtask

    // out_valid must stay low for n cycles
    task automatic expect_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, out_valid, 0);
            step();
        end
    endtask

    // Stream n vectors through, optionally stalling the consumer, and
    // compare every transferred result/tag against the table in order.
    task automatic run_batch(input int n, input int stall_at, input int stall_len, input bit streaming);
        int          issued;
        int          got;
        int          cyc;
        int          first_cyc;
        int          last_cyc;
        logic        held_v;
        logic [31:0] held_r;
        logic [4:0]  held_t;
        issued    = 0;
        got       = 0;
        cyc       = 0;
        first_cyc = -1;
        last_cyc  = -1;
        held_v    = 1'b0;
        held_r    = '0;
        held_t    = '0;
        while (got < n && cyc < 200) begin
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (issued < n) begin
                in_valid = 1'b1;
                in_op    = vec_op[issued];
                in_a     = vec_a[issued];
                in_b     = vec_b[issued];
                in_tag   = vec_tag[issued];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held_v) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_result_held", out_result, held_r);
                check("stall_tag_held", out_tag, held_t);
            end
            if (streaming && issued < n) check("stream_in_ready", in_ready, 1);
            if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                check("batch_tag", out_tag, vec_tag[got]);
                check("batch_result", out_result, vec_exp[got]);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            if (in_valid && in_ready) issued++;
            held_v = out_valid && !out_ready;
            held_r = out_result;
            held_t = out_tag;
            step();
            cyc++;
        end
        check("batch_count", got, n);
        if (streaming) check("stream_consecutive", last_cyc - first_cyc, n - 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;
`ifdef MUL_PIPE_KILL_EN
        kill      = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_result", out_result, 0);
        check("reset_out_tag", out_tag, 0);
        check("reset_in_ready", in_ready, 1);

        // 7 * -3 = -21
        issue_timed(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB);

        // Signedness sweep on 0x80000000 x 0xFFFFFFFF
        set_vec(0, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000);
        set_vec(1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h8000_0000);
        set_vec(2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h7FFF_FFFF);
        set_vec(3, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000);
        run_batch(4, 1000, 0, 1'b1);
        expect_idle("sweep_no_extra", STG + 2);

        // Back-to-back ops, tags 0..7
        set_vec(0, 2'b00, 32'h0000_0003, 32'h0000_0005, 5'd0, 32'h0000_000F);
        set_vec(1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
        set_vec(2, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000);
        set_vec(3, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 32'hFFFF_FFFF);
        set_vec(4, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF);
        set_vec(5, 2'b00, 32'h0001_0000, 32'h0001_0000, 5'd5, 32'h0000_0000);
        set_vec(6, 2'b11, 32'h0001_0000, 32'h0001_0000, 5'd6, 32'h0000_0001);
        set_vec(7, 2'b00, 32'h1234_5678, 32'h0000_0000, 5'd7, 32'h0000_0000);
        run_batch(8, 1000, 0, 1'b1);
        expect_idle("b2b_no_extra", STG + 2);

        // Backpressure: consumer stalls 4 cycles while results are pending
        run_batch(6, STG + 1, 4, 1'b0);
        expect_idle("bp_no_extra", STG + 2);

        // Reset with ops in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_op    = vec_op[i];
            in_a     = vec_a[i];
            in_b     = vec_b[i];
            in_tag   = vec_tag[i];
            step();
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_result", out_result, 0);
        check("midrst_out_tag", out_tag, 0);
        expect_idle("midrst_no_stale", STG + 2);
        issue_timed(2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 5'd17, 32'h0000_000F);

`ifdef MUL_PIPE_KILL_EN
        // Kill with 3 ops in flight plus a simultaneous accept
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_op    = vec_op[i];
            in_a     = vec_a[i];
            in_b     = vec_b[i];
            in_tag   = vec_tag[i];
            step();
        end
        in_op  = 2'b00;
        in_a   = 32'h0000_0002;
        in_b   = 32'h0000_0003;
        in_tag = 5'd30;
        kill   = 1'b1;
        step();
        kill     = 1'b0;
        in_valid = 1'b0;
        check("kill_out_valid", out_valid, 0);
        issue_timed(2'b00, 32'h0000_0006, 32'h0000_0007, 5'd12, 32'h0000_002A);
        expect_idle("kill_no_extra", STG + 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
